trap_sequencer: RTL and testbench

//  Trap scheduler in front of csr_regfile. Arbitrates synchronous exceptions, enabled

---
 rtl/trap_sequencer.sv | 160 ++++++++++++++++
 tb/tb_trap_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Trap scheduler in front of the CSR file: arbitrates exceptions, interrupts and xRET,
// drains the pipeline, strobes the CSR commit for one cycle, then redirects the front end.
module trap_sequencer #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            exc_valid,
  input  logic [4:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            mret_req,
  input  logic            sret_req,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic            m_irq,
  input  logic            m_tmr,
  input  logic            s_irq,
  input  logic            s_tmr,
  input  logic            m_eie,
  input  logic            m_tie,
  input  logic            s_eie,
  input  logic            s_tie,
  output logic            exc_ack,
  output logic            stall,
  output logic            flush,
  output logic            exception_pending,
  output logic [XLEN-1:0] m_cause,
  output logic [XLEN-1:0] pc_exc,
  output logic            m_ret,
  output logic            s_ret,
  output logic            redirect,
  output logic            busy
);

  typedef enum logic [1:0] {StIdle, StDrain, StCommit, StRedirect} state_e;
  typedef enum logic [1:0] {RetNone, RetM, RetS} ret_e;

  localparam logic [3:0]      DrainInit = 4'(DRAIN_CYCLES - 1);
  localparam logic [XLEN-1:0] IrqBit    = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] cause_q, cause_d, pc_q, pc_d;
  ret_e            ret_q, ret_d;

  logic            stall_q, flush_q, pend_q, mret_q, sret_q, redir_q, busy_q;
  logic [XLEN-1:0] mcause_q, pcexc_q;

  logic            accept;
  logic [XLEN-1:0] win_cause, win_pc;
  ret_e            win_ret;

  // Fixed-priority winner; interrupts only count while an instruction is retiring.
  always_comb begin
    accept    = 1'b1;
    win_cause = '0;
    win_pc    = '0;
    win_ret   = RetNone;
    if (exc_valid) begin
      win_cause = {{(XLEN-5){1'b0}}, exc_code};
      win_pc    = exc_pc;
    end else if (mret_req) begin
      win_ret = RetM;
    end else if (sret_req) begin
      win_ret = RetS;
    end else if (commit_valid && m_irq && m_eie) begin
      win_cause = IrqBit | XLEN'(11);
      win_pc    = commit_pc;
    end else if (commit_valid && m_tmr && m_tie) begin
      win_cause = IrqBit | XLEN'(7);
      win_pc    = commit_pc;
    end else if (commit_valid && s_irq && s_eie) begin
      win_cause = IrqBit | XLEN'(9);
      win_pc    = commit_pc;
    end else if (commit_valid && s_tmr && s_tie) begin
      win_cause = IrqBit | XLEN'(5);
      win_pc    = commit_pc;
    end else begin
      accept = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    exc_ack = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // Gated by nrst so the ack stays low while held in reset.
          exc_ack = nrst;
          cause_d = win_cause;
          pc_d    = win_pc;
          ret_d   = win_ret;
          cnt_d   = DrainInit;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (cnt_q == '0) begin
          state_d = StCommit;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StCommit:   state_d = StRedirect;
      StRedirect: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      cause_q  <= '0;
      pc_q     <= '0;
      ret_q    <= RetNone;
      stall_q  <= 1'b0;
      flush_q  <= 1'b0;
      pend_q   <= 1'b0;
      mret_q   <= 1'b0;
      sret_q   <= 1'b0;
      redir_q  <= 1'b0;
      busy_q   <= 1'b0;
      mcause_q <= '0;
      pcexc_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      pc_q     <= pc_d;
      ret_q    <= ret_d;
      stall_q  <= (state_d != StIdle);
      flush_q  <= (state_d == StDrain);
      pend_q   <= (state_d == StCommit);
      mret_q   <= (state_d == StCommit) && (ret_q == RetM);
      sret_q   <= (state_d == StCommit) && (ret_q == RetS);
      redir_q  <= (state_d == StRedirect);
      busy_q   <= (state_d != StIdle);
      mcause_q <= (state_d == StCommit) ? cause_q : '0;
      pcexc_q  <= (state_d == StCommit) ? pc_q : '0;
    end
  end

  assign stall             = stall_q;
  assign flush             = flush_q;
  assign exception_pending = pend_q;
  assign m_ret             = mret_q;
  assign s_ret             = sret_q;
  assign redirect          = redir_q;
  assign busy              = busy_q;
  assign m_cause           = mcause_q;
  assign pc_exc            = pcexc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: two instances (drain 2 and drain 1) checked every cycle against
// a timeline model of the trap sequence, plus directed latency and cause checks.
module tb_trap_sequencer;

  logic        clk;
  logic        nrst;
  logic        ev[2], mr[2], sr[2];
  logic [4:0]  ec[2];
  logic [31:0] epc[2];
  logic        cv;
  logic [31:0] cpc;
  logic        mi, mt, si, st, mei, mti, sei, sti;

  logic        ack[2], stl[2], fl[2], pend[2], mret[2], sret[2], redir[2], bsy[2];
  logic [31:0] mc[2], pce[2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model state: cycles since acceptance (0 = idle) and the latched trap.
  int          phase[2], nphase[2], acc_sel[2];
  logic [31:0] lat_mc[2], lat_pc[2];
  int          lat_ret[2];

  int          ack_cyc[2], strobe_cyc[2], redir_cyc[2];
  logic [31:0] q_cause[$];
  logic [31:0] q_pc[$];
  logic        q_mret[$];

  trap_sequencer #(.XLEN(32), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .nrst(nrst), .exc_valid(ev[0]), .exc_code(ec[0]), .exc_pc(epc[0]),
    .mret_req(mr[0]), .sret_req(sr[0]), .commit_valid(cv), .commit_pc(cpc),
    .m_irq(mi), .m_tmr(mt), .s_irq(si), .s_tmr(st),
    .m_eie(mei), .m_tie(mti), .s_eie(sei), .s_tie(sti),
    .exc_ack(ack[0]), .stall(stl[0]), .flush(fl[0]), .exception_pending(pend[0]),
    .m_cause(mc[0]), .pc_exc(pce[0]), .m_ret(mret[0]), .s_ret(sret[0]),
    .redirect(redir[0]), .busy(bsy[0])
  );

  trap_sequencer #(.XLEN(32), .DRAIN_CYCLES(1)) dut_d1 (
    .clk(clk), .nrst(nrst), .exc_valid(ev[1]), .exc_code(ec[1]), .exc_pc(epc[1]),
    .mret_req(mr[1]), .sret_req(sr[1]), .commit_valid(cv), .commit_pc(cpc),
    .m_irq(mi), .m_tmr(mt), .s_irq(si), .s_tmr(st),
    .m_eie(mei), .m_tie(mti), .s_eie(sei), .s_tie(sti),
    .exc_ack(ack[1]), .stall(stl[1]), .flush(fl[1]), .exception_pending(pend[1]),
    .m_cause(mc[1]), .pc_exc(pce[1]), .m_ret(mret[1]), .s_ret(sret[1]),
    .redirect(redir[1]), .busy(bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic eval(input int k);
    int          d, sel;
    int          codes[4];
    bit          elig[4];
    logic [31:0] wc, wp;
    int          wr;
    logic        e_ack, e_stall, e_flush, e_pend, e_mret, e_sret, e_redir, e_busy;
    logic [31:0] e_mc, e_pc;
    d = (k == 0) ? 2 : 1;
    {e_ack, e_stall, e_flush, e_pend, e_mret, e_sret, e_redir, e_busy} = '0;
    e_mc = '0;
    e_pc = '0;
    sel = 0;
    wc = '0;
    wp = '0;
    wr = 0;
    nphase[k] = phase[k];
    if (!nrst) begin
      nphase[k]  = 0;
      lat_mc[k]  = '0;
      lat_pc[k]  = '0;
      lat_ret[k] = 0;
    end else if (phase[k] == 0) begin
      codes = '{11, 7, 9, 5};
      elig  = '{mi && mei, mt && mti, si && sei, st && sti};
      if (ev[k]) begin
        sel = 1; wc = 32'(ec[k]); wp = epc[k];
      end else if (mr[k]) begin
        sel = 2; wr = 1;
      end else if (sr[k]) begin
        sel = 3; wr = 2;
      end else if (cv) begin
        for (int i = 0; i < 4; i++) begin
          if (sel == 0 && elig[i]) begin
            sel = 4; wc = 32'h8000_0000 | 32'(codes[i]); wp = cpc;
          end
        end
      end
      if (sel != 0) begin
        e_ack      = 1'b1;
        lat_mc[k]  = wc;
        lat_pc[k]  = wp;
        lat_ret[k] = wr;
        nphase[k]  = 1;
      end
    end else begin
      e_stall = 1'b1;
      e_busy  = 1'b1;
      if (phase[k] <= d) begin
        e_flush = 1'b1;
      end else if (phase[k] == d + 1) begin
        e_pend = 1'b1;
        e_mc   = lat_mc[k];
        e_pc   = lat_pc[k];
        e_mret = (lat_ret[k] == 1);
        e_sret = (lat_ret[k] == 2);
      end else begin
        e_redir = 1'b1;
      end
      nphase[k] = (phase[k] == d + 2) ? 0 : phase[k] + 1;
    end
    acc_sel[k] = sel;
    check_eq($sformatf("ack%0d", k), 64'(ack[k]), 64'(e_ack));
    check_eq($sformatf("stall%0d", k), 64'(stl[k]), 64'(e_stall));
    check_eq($sformatf("flush%0d", k), 64'(fl[k]), 64'(e_flush));
    check_eq($sformatf("pend%0d", k), 64'(pend[k]), 64'(e_pend));
    check_eq($sformatf("mcause%0d", k), 64'(mc[k]), 64'(e_mc));
    check_eq($sformatf("pcexc%0d", k), 64'(pce[k]), 64'(e_pc));
    check_eq($sformatf("mret%0d", k), 64'(mret[k]), 64'(e_mret));
    check_eq($sformatf("sret%0d", k), 64'(sret[k]), 64'(e_sret));
    check_eq($sformatf("redir%0d", k), 64'(redir[k]), 64'(e_redir));
    check_eq($sformatf("busy%0d", k), 64'(bsy[k]), 64'(e_busy));
    if (ack[k] === 1'b1) ack_cyc[k] = cyc;
    if (pend[k] === 1'b1) strobe_cyc[k] = cyc;
    if (redir[k] === 1'b1) redir_cyc[k] = cyc;
    if (k == 0 && pend[0] === 1'b1) begin
      q_cause.push_back(mc[0]);
      q_pc.push_back(pce[0]);
      q_mret.push_back(mret[0]);
    end
  endtask

  // One clock: check at negedge, advance model, release accepted requests after the edge.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) eval(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      phase[k] = nphase[k];
      if (acc_sel[k] == 1) ev[k] = 1'b0;
      if (acc_sel[k] == 2) mr[k] = 1'b0;
      if (acc_sel[k] == 3) sr[k] = 1'b0;
    end
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_marks();
    for (int k = 0; k < 2; k++) begin
      ack_cyc[k] = -1; strobe_cyc[k] = -1; redir_cyc[k] = -1;
    end
    q_cause.delete();
    q_pc.delete();
    q_mret.delete();
  endtask

  task automatic irqs_off();
    {mi, mt, si, st, mei, mti, sei, sti} = '0;
    cv = 1'b0;
  endtask

  initial begin
    nrst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ev[k] = 1'b0; mr[k] = 1'b0; sr[k] = 1'b0; ec[k] = '0; epc[k] = '0;
      phase[k] = 0; nphase[k] = 0; acc_sel[k] = 0;
      lat_mc[k] = '0; lat_pc[k] = '0; lat_ret[k] = 0;
    end
    cpc = '0;
    irqs_off();
    clear_marks();

    // Reset with a pending but disabled interrupt; nothing may start.
    mi = 1'b1;
    steps(2);
    nrst = 1'b1;
    cv = 1'b1;
    steps(4);
    check_eq("idle_no_ack", 64'(ack_cyc[0]), 64'hffff_ffff_ffff_ffff);
    irqs_off();

    // Exception timeline; second instance has a one-cycle drain.
    clear_marks();
    for (int k = 0; k < 2; k++) begin
      ev[k] = 1'b1; ec[k] = 5'd2; epc[k] = 32'h100;
    end
    steps(7);
    check_eq("exc_strobe_lat", 64'(strobe_cyc[0] - ack_cyc[0]), 64'd3);
    check_eq("exc_redir_lat", 64'(redir_cyc[0] - strobe_cyc[0]), 64'd1);
    check_eq("exc_strobe_lat_d1", 64'(strobe_cyc[1] - ack_cyc[1]), 64'd2);
    check_eq("exc_cause", 64'(q_cause.size() > 0 ? q_cause[0] : 32'hdead), 64'h2);
    check_eq("exc_pc", 64'(q_pc.size() > 0 ? q_pc[0] : 32'hdead), 64'h100);

    // Machine timer; lines drop right after acceptance.
    clear_marks();
    mt = 1'b1; mti = 1'b1; cv = 1'b1; cpc = 32'h204;
    step();
    irqs_off();
    steps(6);
    check_eq("mtmr_cause", 64'(q_cause.size() > 0 ? q_cause[0] : 32'hdead), 64'h8000_0007);
    check_eq("mtmr_pc", 64'(q_pc.size() > 0 ? q_pc[0] : 32'hdead), 64'h204);

    // Exception beats MRET and M ext; held MRET follows back-to-back.
    clear_marks();
    for (int k = 0; k < 2; k++) begin
      ev[k] = 1'b1; ec[k] = 5'd8; epc[k] = 32'h300; mr[k] = 1'b1;
    end
    mi = 1'b1; mei = 1'b1; cv = 1'b1; cpc = 32'h400;
    step();
    irqs_off();
    steps(11);
    check_eq("prio_count", 64'(q_cause.size()), 64'd2);
    check_eq("prio_cause", 64'(q_cause.size() > 0 ? q_cause[0] : 32'hdead), 64'h8);
    check_eq("mret_flag", 64'(q_mret.size() > 1 ? q_mret[1] : 1'b0), 64'd1);
    check_eq("mret_cause", 64'(q_cause.size() > 1 ? q_cause[1] : 32'hdead), 64'h0);

    // Interrupt priority: M timer over S ext, then S ext once M timer is disabled.
    clear_marks();
    si = 1'b1; sei = 1'b1; mt = 1'b1; mti = 1'b1; cv = 1'b1; cpc = 32'h500;
    step();
    irqs_off();
    steps(6);
    check_eq("mtmr_over_sext", 64'(q_cause.size() > 0 ? q_cause[0] : 32'hdead), 64'h8000_0007);
    clear_marks();
    si = 1'b1; sei = 1'b1; mt = 1'b1; mti = 1'b0; cv = 1'b1;
    step();
    irqs_off();
    steps(6);
    check_eq("sext_cause", 64'(q_cause.size() > 0 ? q_cause[0] : 32'hdead), 64'h8000_0009);

    // Reset in the middle of DRAIN aborts the sequence.
    clear_marks();
    for (int k = 0; k < 2; k++) begin
      ev[k] = 1'b1; ec[k] = 5'd1; epc[k] = 32'h40;
    end
    steps(2);
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    steps(6);
    check_eq("abort_no_strobe", 64'(q_cause.size()), 64'd0);
    check_eq("abort_no_redir", 64'(redir_cyc[0]), 64'hffff_ffff_ffff_ffff);
    check_eq("abort_busy", 64'(bsy[0]), 64'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      mi  = ($urandom_range(0, 3) == 0); mt  = ($urandom_range(0, 3) == 0);
      si  = ($urandom_range(0, 3) == 0); st  = ($urandom_range(0, 3) == 0);
      mei = $urandom_range(0, 1);        mti = $urandom_range(0, 1);
      sei = $urandom_range(0, 1);        sti = $urandom_range(0, 1);
      cv  = $urandom_range(0, 1);
      cpc = $urandom;
      for (int k = 0; k < 2; k++) begin
        if (!(ev[k] || mr[k] || sr[k]) && $urandom_range(0, 4) == 0) begin
          ev[k]  = $urandom_range(0, 1);
          mr[k]  = $urandom_range(0, 1);
          sr[k]  = $urandom_range(0, 1);
          ec[k]  = 5'($urandom);
          epc[k] = $urandom;
        end
      end
      nrst = ($urandom_range(0, 499) != 0);
      step();
    end
    nrst = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
